// File: rtl/reg16_serial_reader.sv
// Parallel-in, bit-serial-out reader: captures a word over a valid/ready load
// handshake and shifts it out one bit per accepted serial transfer.
//
// state | meaning
// IDLE  | waiting for a word; Load_Ready high
// SHIFT | presenting bits; Ser_Valid high, advances on Ser_Ready
// DONE  | one-cycle completion pulse, then back to IDLE
module reg16_serial_reader #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           D,
  input  logic                       Load_Valid,
  output logic                       Load_Ready,
  output logic                       Ser_Out,
  output logic                       Ser_Valid,
  input  logic                       Ser_Ready,
  output logic [$clog2(WIDTH+1)-1:0] Bits_Sent,
  output logic                       Done
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Load_Valid) begin
          shreg_d = D;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Ser_Valid is constant in SHIFT, so a transfer is just Ser_Ready.
        if (Ser_Ready) begin
          if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign Load_Ready = (state_q == IDLE);
  assign Ser_Valid  = (state_q == SHIFT);
  assign Done       = (state_q == DONE);
  assign Ser_Out    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign Bits_Sent  = cnt_q;

endmodule

// File: tb/tb_reg16_serial_reader.sv
// Directed bench for reg16_serial_reader: MSB-first and LSB-first instances
// share inputs; expected bit streams and cycle positions are hand-derived.
module tb_reg16_serial_reader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] D;
  logic        Load_Valid;
  logic        Ser_Ready;

  logic        m_load_ready, m_ser_out, m_ser_valid, m_done;
  logic [4:0]  m_bits_sent;
  logic        l_load_ready, l_ser_out, l_ser_valid, l_done;
  logic [4:0]  l_bits_sent;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  reg16_serial_reader #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .Clk(Clk), .Reset(Reset), .D(D), .Load_Valid(Load_Valid),
    .Load_Ready(m_load_ready), .Ser_Out(m_ser_out), .Ser_Valid(m_ser_valid),
    .Ser_Ready(Ser_Ready), .Bits_Sent(m_bits_sent), .Done(m_done)
  );

  reg16_serial_reader #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(Clk), .Reset(Reset), .D(D), .Load_Valid(Load_Valid),
    .Load_Ready(l_load_ready), .Ser_Out(l_ser_out), .Ser_Valid(l_ser_valid),
    .Ser_Ready(Ser_Ready), .Bits_Sent(l_bits_sent), .Done(l_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Load accepted at edge N; returns in cycle N+1. D is scrambled afterwards.
  task automatic do_load(input logic [15:0] w);
    D = w;
    Load_Valid = 1'b1;
    tick();
    Load_Valid = 1'b0;
    D = 16'h0000;
  endtask

  // Called in cycle N+1 with Ser_Ready=1; returns in cycle N+17 (Done cycle).
  // inject >= 0 raises Load_Valid with D=16'h1234 from that bit onwards.
  task automatic expect_word(input string tag, input logic [15:0] w, input bit lsb,
                             input int inject);
    logic exp_bit;
    for (int i = 0; i < 16; i++) begin
      exp_bit = lsb ? w[i] : w[15-i];
      if (i == inject) begin
        Load_Valid = 1'b1;
        D = 16'h1234;
      end
      if (lsb) begin
        chk({tag, " ser_out"},   {31'd0, l_ser_out},   {31'd0, exp_bit});
        chk({tag, " ser_valid"}, {31'd0, l_ser_valid}, 32'd1);
        chk({tag, " bits_sent"}, {27'd0, l_bits_sent}, i);
        chk({tag, " done_low"},  {31'd0, l_done},      32'd0);
      end else begin
        chk({tag, " ser_out"},   {31'd0, m_ser_out},   {31'd0, exp_bit});
        chk({tag, " ser_valid"}, {31'd0, m_ser_valid}, 32'd1);
        chk({tag, " bits_sent"}, {27'd0, m_bits_sent}, i);
        chk({tag, " done_low"},  {31'd0, m_done},      32'd0);
        chk({tag, " load_rdy_low"}, {31'd0, m_load_ready}, 32'd0);
      end
      tick();
    end
    if (lsb) begin
      chk({tag, " done"},      {31'd0, l_done},      32'd1);
      chk({tag, " bits_16"},   {27'd0, l_bits_sent}, 32'd16);
      chk({tag, " valid_off"}, {31'd0, l_ser_valid}, 32'd0);
      chk({tag, " ldrdy_off"}, {31'd0, l_load_ready}, 32'd0);
    end else begin
      chk({tag, " done"},      {31'd0, m_done},      32'd1);
      chk({tag, " bits_16"},   {27'd0, m_bits_sent}, 32'd16);
      chk({tag, " valid_off"}, {31'd0, m_ser_valid}, 32'd0);
      chk({tag, " ldrdy_off"}, {31'd0, m_load_ready}, 32'd0);
    end
  endtask

  int xfers;

  initial begin
    Reset = 1'b0;
    D = 16'h0000;
    Load_Valid = 1'b0;
    Ser_Ready = 1'b1;

    // Reset held for three edges
    tick(); tick(); tick();
    chk("rst load_ready", {31'd0, m_load_ready}, 32'd1);
    chk("rst ser_valid",  {31'd0, m_ser_valid},  32'd0);
    chk("rst done",       {31'd0, m_done},       32'd0);
    chk("rst bits_sent",  {27'd0, m_bits_sent},  32'd0);
    chk("rst ser_out",    {31'd0, m_ser_out},    32'd0);
    chk("rst lsb ser_out", {31'd0, l_ser_out},   32'd0);
    Reset = 1'b1;
    tick();
    chk("idle load_ready", {31'd0, m_load_ready}, 32'd1);

    // MSB-first readout of A5C3
    do_load(16'hA5C3);
    expect_word("msb", 16'hA5C3, 1'b0, -1);
    tick();
    chk("msb n18 load_ready", {31'd0, m_load_ready}, 32'd1);
    chk("msb n18 done",       {31'd0, m_done},       32'd0);
    chk("msb n18 bits",       {27'd0, m_bits_sent},  32'd0);

    // LSB-first readout of 0001
    do_load(16'h0001);
    expect_word("lsb", 16'h0001, 1'b1, -1);
    tick();
    chk("lsb done once",  {31'd0, l_done},       32'd0);
    chk("lsb load_ready", {31'd0, l_load_ready}, 32'd1);

    // Backpressure: Ser_Ready low for cycles N+3..N+7
    do_load(16'hFFFF);
    xfers = 0;
    for (int c = 1; c <= 21; c++) begin
      Ser_Ready = !(c >= 3 && c <= 7);
      if (c >= 3 && c <= 7) begin
        chk("bp hold bits",  {27'd0, m_bits_sent}, 32'd2);
        chk("bp hold valid", {31'd0, m_ser_valid}, 32'd1);
        chk("bp hold out",   {31'd0, m_ser_out},   32'd1);
      end
      chk("bp no early done", {31'd0, m_done}, 32'd0);
      if (m_ser_valid && Ser_Ready) xfers++;
      tick();
    end
    Ser_Ready = 1'b1;
    chk("bp done n22",   {31'd0, m_done},      32'd1);
    chk("bp bits 16",    {27'd0, m_bits_sent}, 32'd16);
    chk("bp xfer count", xfers,                32'd16);
    tick();

    // Load attempt during SHIFT is ignored; new word taken at N+18
    do_load(16'hA5C3);
    expect_word("ign", 16'hA5C3, 1'b0, 2);
    tick();
    chk("ign n18 load_ready", {31'd0, m_load_ready}, 32'd1);
    tick();
    Load_Valid = 1'b0;
    D = 16'h0000;
    expect_word("new", 16'h1234, 1'b0, -1);
    tick();

    // Reset in the middle of a word
    do_load(16'hA5C3);
    for (int i = 0; i < 7; i++) tick();
    chk("mid bits 7", {27'd0, m_bits_sent}, 32'd7);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("mid rst valid",  {31'd0, m_ser_valid},  32'd0);
    chk("mid rst bits",   {27'd0, m_bits_sent},  32'd0);
    chk("mid rst ldrdy",  {31'd0, m_load_ready}, 32'd1);
    chk("mid rst out",    {31'd0, m_ser_out},    32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("mid no done", {31'd0, m_done}, 32'd0);
      tick();
    end
    do_load(16'h00FF);
    expect_word("post", 16'h00FF, 1'b0, -1);
    tick();
    chk("post idle", {31'd0, m_load_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg16_serial_reader.md
Name: reg16_serial_reader

Overview:
- Reader-side counterpart to the team's 16-bit load register.
- Accepts a parallel word from a register output (e.g. switch value or adder sum) via a valid/ready handshake, then shifts it out one bit per accepted transfer.
- Serial output has its own valid/ready backpressure handshake.
- Sits between datapath registers and a bit-serial consumer: debug LED chaser, serial link, or shift-add multiplier operand feed.

Parameters:
- WIDTH, 16, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first, 0 = shift out bit 0 first.

Ports:
- Clk  input  1  system clock; all state updates on posedge Clk.
- Reset  input  1  synchronous, active-low reset; 0 sampled at posedge Clk resets the block.
- D  input  WIDTH  parallel word to be read out.
- Load_Valid  input  1  D is valid and requests readout.
- Load_Ready  output  1  block can accept a new word.
- Ser_Out  output  1  current serial bit.
- Ser_Valid  output  1  Ser_Out holds a valid bit.
- Ser_Ready  input  1  consumer accepts Ser_Out this cycle.
- Bits_Sent  output  $clog2(WIDTH+1)  number of bits accepted so far for the current word.
- Done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- **Reset.** Reset==0 at posedge takes priority over all else, including mid-word.
  - State = IDLE; shift register = 0; Bits_Sent = 0.
  - Ser_Out = 0, Ser_Valid = 0, Done = 0, Load_Ready = 1 (IDLE value).
  - A word aborted by reset produces no Done pulse.
- **All outputs are registered or decoded from the state register only.** No combinational path from Ser_Ready or Load_Valid to any output.
- **IDLE.**
  - Load_Ready=1, Ser_Valid=0, Done=0.
  - Load_Valid=1 at posedge: capture D into shift register, Bits_Sent=0, go to SHIFT.
- **SHIFT.**
  - Load_Ready=0, Ser_Valid=1.
  - Ser_Out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - Transfer occurs at a posedge with Ser_Valid=1 and Ser_Ready=1:
    - shift register shifts toward the output end, zero-filled;
    - Bits_Sent increments.
  - Transfer with Bits_Sent==WIDTH-1: Bits_Sent becomes WIDTH, go to DONE.
  - Ser_Ready=0: shift register, Ser_Out and Bits_Sent all hold. Ser_Valid stays 1 (no retraction once asserted).
- **DONE.**
  - Done=1 for exactly one cycle; Load_Ready=0, Ser_Valid=0, Bits_Sent=WIDTH.
  - Unconditionally returns to IDLE next cycle.
  - On re-entry to IDLE, Bits_Sent is cleared to 0.
- **Load_Valid outside IDLE** (SHIFT or DONE) is ignored, since Load_Ready=0. D changes after capture have no effect on the word in flight.
- **Latency.** Load accepted at edge N, Ser_Ready held 1:
  - first bit valid in cycle N+1;
  - WIDTH-th bit accepted at edge N+WIDTH;
  - Done high in cycle N+WIDTH+1;
  - Load_Ready high again in cycle N+WIDTH+2.
  - Throughput is one word per WIDTH+2 cycles.
- **Stall behaviour.** Each Ser_Ready=0 cycle in SHIFT adds exactly one cycle to the latency.
- **Undefined states** recover to IDLE on the next clock.

Test Plan:
1. **Reset.** Hold Reset=0 for 3 cycles, release.
   - Load_Ready=1, Ser_Valid=0, Done=0, Bits_Sent=0, Ser_Out=0.
2. **MSB-first readout.** MSB_FIRST=1, D=16'hA5C3, Load_Valid pulsed 1 cycle, Ser_Ready=1.
   - Ser_Out sequence 1010_0101_1100_0011 over cycles N+1..N+16.
   - Done pulse exactly at N+17; Load_Ready=1 at N+18.
3. **LSB-first readout.** MSB_FIRST=0, D=16'h0001.
   - First bit 1, then 15 zeros.
   - Bits_Sent steps 0..16; Done once.
4. **Backpressure.** D=16'hFFFF, Ser_Ready=0 for cycles N+3..N+7.
   - Ser_Out and Bits_Sent (=2) hold with Ser_Valid=1.
   - Done delayed to N+22; exactly 16 bits transferred.
5. **Ignored load and input isolation.** Load_Valid=1 with D=16'h1234 during SHIFT of word 16'hA5C3.
   - Output still 16'hA5C3's bits.
   - The new word is accepted only when Load_Ready=1 (cycle N+18).
6. **Reset mid-word.** Reset=0 at bit 7 of 16'hA5C3.
   - Next cycle: IDLE, Ser_Valid=0, Bits_Sent=0, no Done pulse.
   - A subsequent load of 16'h00FF reads out correctly.
